// File: rtl/fpu_div_issue.sv
// fpu_div_issue: request FIFO and issue/collect stage in front of the
// multi-cycle FPU divider.
//
// Ports:
//   clk, reset (async, active-low)
//   req_valid/req_ready/req_a/req_b/req_tag : request push interface
//   div_valid/div_din1/div_din2             : one-cycle launch to the divider
//   div_result/div_ready                    : divider completion pulse
//   rsp_valid/rsp_ready/rsp_result/rsp_tag  : held, tagged response
//   rsp_timeout                             : response made by the watchdog
//   busy                                    : operation in ISSUE or WAIT
//   fault                                   : sticky watchdog fault
module fpu_div_issue #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned TIMEOUT = 512
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic             div_valid,
  output logic [31:0]      div_din1,
  output logic [31:0]      div_din2,
  input  logic [31:0]      div_result,
  input  logic             div_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_timeout,
  output logic             busy,
  output logic             fault
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned WD_W  = $clog2(TIMEOUT) + 1;
  localparam logic [31:0] QNAN  = 32'h7FC0_0000;

  typedef struct packed {
    logic [31:0]      a;
    logic [31:0]      b;
    logic [TAG_W-1:0] tag;
  } req_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_FAULT
  } state_e;

  state_e           state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WD_W-1:0]  wdog_q, wdog_d;
  logic [TAG_W-1:0] fl_tag_q, fl_tag_d;
  logic             div_valid_q, div_valid_d;
  logic [31:0]      din1_q, din1_d;
  logic [31:0]      din2_q, din2_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_result_q, rsp_result_d;
  logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
  logic             rsp_timeout_q, rsp_timeout_d;
  logic             busy_q, busy_d;
  logic             fault_q, fault_d;

  req_t             mem_q [DEPTH];
  req_t             head_c;
  logic             req_ready_c;
  logic             push_c;
  logic             pop_c;

  // Full or faulted FIFO refuses new requests.
  assign req_ready_c = (count_q != CNT_W'(DEPTH)) && !fault_q;
  assign push_c      = req_valid && req_ready_c;
  assign head_c      = mem_q[rd_ptr_q];

  // FIFO storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= '{a: req_a, b: req_b, tag: req_tag};
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      wdog_q        <= '0;
      fl_tag_q      <= '0;
      div_valid_q   <= 1'b0;
      din1_q        <= '0;
      din2_q        <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_result_q  <= '0;
      rsp_tag_q     <= '0;
      rsp_timeout_q <= 1'b0;
      busy_q        <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      wdog_q        <= wdog_d;
      fl_tag_q      <= fl_tag_d;
      div_valid_q   <= div_valid_d;
      din1_q        <= din1_d;
      din2_q        <= din2_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_result_q  <= rsp_result_d;
      rsp_tag_q     <= rsp_tag_d;
      rsp_timeout_q <= rsp_timeout_d;
      busy_q        <= busy_d;
      fault_q       <= fault_d;
    end
  end

  // Next-state: issue FSM, watchdog, response capture and FIFO pointers.
  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    wdog_d        = wdog_q;
    fl_tag_d      = fl_tag_q;
    din1_d        = din1_q;
    din2_d        = din2_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_result_d  = rsp_result_q;
    rsp_tag_d     = rsp_tag_q;
    rsp_timeout_d = rsp_timeout_q;
    fault_d       = fault_q;
    pop_c         = 1'b0;

    // Consumer handshake; never coincides with a capture since WAIT
    // is only reached with rsp_valid low.
    if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        // One operation outstanding or held at a time.
        if ((count_q != '0) && !rsp_valid_q) begin
          state_d  = S_ISSUE;
          din1_d   = head_c.a;
          din2_d   = head_c.b;
          fl_tag_d = head_c.tag;
        end
      end
      S_ISSUE: begin
        pop_c   = 1'b1;
        wdog_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A completion on the last allowed cycle still wins over the watchdog.
        if (div_ready) begin
          rsp_result_d  = div_result;
          rsp_tag_d     = fl_tag_q;
          rsp_timeout_d = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = S_IDLE;
        end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
          rsp_result_d  = QNAN;
          rsp_tag_d     = fl_tag_q;
          rsp_timeout_d = 1'b1;
          rsp_valid_d   = 1'b1;
          fault_d       = 1'b1;
          state_d       = S_FAULT;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (push_c) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);

    // Launch strobe and busy mirror the registered state.
    div_valid_d = (state_d == S_ISSUE);
    busy_d      = (state_d == S_ISSUE) || (state_d == S_WAIT);
  end

  assign req_ready   = req_ready_c;
  assign div_valid   = div_valid_q;
  assign div_din1    = din1_q;
  assign div_din2    = din2_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_tag     = rsp_tag_q;
  assign rsp_timeout = rsp_timeout_q;
  assign busy        = busy_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_fpu_div_issue.sv
// tb_fpu_div_issue: directed bench for fpu_div_issue (DEPTH=4, TAG_W=4,
// TIMEOUT=512). The divider is played by the bench cycle by cycle.
module tb_fpu_div_issue;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  req_tag;
  logic        div_valid;
  logic [31:0] div_din1;
  logic [31:0] div_din2;
  logic [31:0] div_result;
  logic        div_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_tag;
  logic        rsp_timeout;
  logic        busy;
  logic        fault;

  int tests = 0;
  int fails = 0;

  fpu_div_issue #(.DEPTH(4), .TAG_W(4), .TIMEOUT(512)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_tag     (req_tag),
    .div_valid   (div_valid),
    .div_din1    (div_din1),
    .div_din2    (div_din2),
    .div_result  (div_result),
    .div_ready   (div_ready),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result),
    .rsp_tag     (rsp_tag),
    .rsp_timeout (rsp_timeout),
    .busy        (busy),
    .fault       (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tg, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tg, obs, exp);
    end
  endtask

  // One clock; a request accepted at this edge is withdrawn afterwards.
  task automatic tick();
    logic acc;
    acc = req_valid && req_ready;
    @(posedge clk);
    #1;
    if (acc) req_valid = 1'b0;
  endtask

  function automatic logic [31:0] a_of(input int t);
    return 32'h4100_0000 | 32'(t);
  endfunction

  task automatic push_req(input int t);
    req_valid = 1'b1;
    req_a     = a_of(t);
    req_b     = 32'h3F80_0000;
    req_tag   = 4'(t);
    tick();
  endtask

  task automatic wait_dv(input string tg, input logic [31:0] a_exp);
    int n;
    n = 0;
    while (div_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({tg, "_div_valid"}, 32'(div_valid), 32'd1);
    check({tg, "_din1"}, div_din1, a_exp);
  endtask

  // Divider completion pulse during the current cycle, then response check.
  task automatic respond(input string tg, input int t, input logic [31:0] res);
    div_ready  = 1'b1;
    div_result = res;
    tick();
    div_ready  = 1'b0;
    check({tg, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
    check({tg, "_rsp_result"}, rsp_result, res);
    check({tg, "_rsp_tag"}, 32'(rsp_tag), 32'(t));
    check({tg, "_rsp_timeout"}, 32'(rsp_timeout), 32'd0);
  endtask

  task automatic handshake(input string tg);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check({tg, "_rsp_cleared"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    int bad;
    reset      = 1'b0;
    req_valid  = 1'b0;
    req_a      = '0;
    req_b      = '0;
    req_tag    = '0;
    div_result = '0;
    div_ready  = 1'b0;
    rsp_ready  = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_div_valid", 32'(div_valid), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_din1", div_din1, 32'd0);
    reset = 1'b1;
    tick();

    // Single op: 6.0 / 2.0 = 3.0, tag 3
    req_valid = 1'b1;
    req_a     = 32'h40C0_0000;
    req_b     = 32'h4000_0000;
    req_tag   = 4'd3;
    tick();
    check("single_no_bypass", 32'(div_valid), 32'd0);
    tick();
    check("single_div_valid", 32'(div_valid), 32'd1);
    check("single_din1", div_din1, 32'h40C0_0000);
    check("single_din2", div_din2, 32'h4000_0000);
    check("single_busy", 32'(busy), 32'd1);
    tick();
    check("single_strobe_len", 32'(div_valid), 32'd0);
    repeat (58) tick();
    check("single_no_early_rsp", 32'(rsp_valid), 32'd0);
    respond("single", 3, 32'h4040_0000);
    check("single_idle_busy", 32'(busy), 32'd0);
    check("single_din_held", div_din1, 32'h40C0_0000);
    handshake("single");

    // Back-pressure: five accepts, sixth waits until the FIFO drains
    for (int i = 0; i < 6; i++) begin
      check($sformatf("bp_req_ready_%0d", i), 32'(req_ready), (i < 5) ? 32'd1 : 32'd0);
      req_valid = 1'b1;
      req_a     = a_of(i);
      req_b     = 32'h3F80_0000;
      req_tag   = 4'(i);
      if (i < 5) tick();
    end
    repeat (90) tick();
    check("bp_still_full", 32'(req_ready), 32'd0);
    check("bp_no_rsp", 32'(rsp_valid), 32'd0);
    respond("bp0", 0, 32'h4040_0000);
    handshake("bp0");
    for (int t = 1; t < 6; t++) begin
      wait_dv($sformatf("bp%0d", t), a_of(t));
      tick();
      respond($sformatf("bp%0d", t), t, 32'h4040_0000 + 32'(t));
      handshake($sformatf("bp%0d", t));
    end
    check("bp_all_pushed", 32'(req_valid), 32'd0);

    // Response stall with two requests queued behind
    push_req(7);
    push_req(8);
    push_req(9);
    check("stall_issue7_din1", div_din1, a_of(7));
    respond("stall7", 7, 32'h3F00_0000);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (div_valid !== 1'b0 || rsp_valid !== 1'b1 ||
          rsp_result !== 32'h3F00_0000 || rsp_tag !== 4'd7) bad++;
      tick();
    end
    check("stall_stable", 32'(bad), 32'd0);
    handshake("stall7");
    check("stall_gap1", 32'(div_valid), 32'd0);
    tick();
    check("stall_gap2_dv", 32'(div_valid), 32'd1);
    check("stall_gap2_din1", div_din1, a_of(8));
    tick();
    respond("stall8", 8, 32'h3F00_0008);
    handshake("stall8");
    wait_dv("stall9", a_of(9));
    tick();
    respond("stall9", 9, 32'h3F00_0009);
    handshake("stall9");

    // Spurious div_ready in IDLE
    tick();
    div_ready  = 1'b1;
    div_result = 32'hDEAD_BEEF;
    tick();
    div_ready  = 1'b0;
    tick();
    check("spur_rsp_valid", 32'(rsp_valid), 32'd0);
    check("spur_busy", 32'(busy), 32'd0);

    // div_ready on the last watchdog cycle still gives a normal response
    push_req(10);
    wait_dv("coin", a_of(10));
    repeat (512) tick();
    check("coin_pre_rsp", 32'(rsp_valid), 32'd0);
    respond("coin", 10, 32'h4120_0000);
    check("coin_fault", 32'(fault), 32'd0);
    handshake("coin");

    // Watchdog timeout
    push_req(11);
    wait_dv("to", a_of(11));
    repeat (512) tick();
    check("to_not_yet", 32'(rsp_valid), 32'd0);
    check("to_not_yet_fault", 32'(fault), 32'd0);
    tick();
    check("to_rsp_valid", 32'(rsp_valid), 32'd1);
    check("to_rsp_result", rsp_result, 32'h7FC0_0000);
    check("to_rsp_tag", 32'(rsp_tag), 32'd11);
    check("to_rsp_timeout", 32'(rsp_timeout), 32'd1);
    check("to_fault", 32'(fault), 32'd1);
    check("to_req_ready", 32'(req_ready), 32'd0);
    check("to_busy", 32'(busy), 32'd0);
    handshake("to");
    req_valid = 1'b1;
    req_tag   = 4'd12;
    div_ready = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (req_ready !== 1'b0 || div_valid !== 1'b0 || rsp_valid !== 1'b0 || fault !== 1'b1) bad++;
      tick();
    end
    div_ready = 1'b0;
    req_valid = 1'b0;
    check("fault_frozen", 32'(bad), 32'd0);
    reset = 1'b0;
    #1;
    check("fault_reset_clear", 32'(fault), 32'd0);
    check("fault_reset_req_ready", 32'(req_ready), 32'd1);
    tick();
    reset = 1'b1;
    tick();

    // Reset in the middle of WAIT with two entries queued
    push_req(1);
    push_req(2);
    push_req(3);
    check("rmw_busy", 32'(busy), 32'd1);
    repeat (19) tick();
    reset = 1'b0;
    #1;
    check("rmw_div_valid", 32'(div_valid), 32'd0);
    check("rmw_din1", div_din1, 32'd0);
    check("rmw_din2", div_din2, 32'd0);
    check("rmw_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rmw_rsp_result", rsp_result, 32'd0);
    check("rmw_rsp_tag", 32'(rsp_tag), 32'd0);
    check("rmw_rsp_timeout", 32'(rsp_timeout), 32'd0);
    check("rmw_busy_clr", 32'(busy), 32'd0);
    check("rmw_fault", 32'(fault), 32'd0);
    check("rmw_req_ready", 32'(req_ready), 32'd1);
    tick();
    tick();
    reset = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (div_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("rmw_fifo_empty", 32'(bad), 32'd0);
    div_ready  = 1'b1;
    div_result = 32'h1234_5678;
    tick();
    div_ready  = 1'b0;
    tick();
    check("rmw_late_ready", 32'(rsp_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
